pong_vga_renderer: RTL and testbench

Display end of the gameplay-to-screen interface for the Pong design. Takes ball position, paddle positions and seven-segment score patterns from the gameplay logic and turns them into 640x480 VGA timing and 8-bit RGB pixels. Also emits a once-per-frame tick that gameplay uses as its update strobe. Positions are in absolute counter coordinates, so back porches are already included.

---
 rtl/pong_vga_renderer.sv | 161 ++++++++++++++++
 tb/tb_pong_vga_renderer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pong_vga_renderer.sv
// Pong display back end: VGA timing counters, once-per-frame input snapshot,
// object/score rendering, with all pins registered one cycle behind hc/vc.
module pong_vga_renderer #(
    parameter int HBP    = 144,
    parameter int HFP    = 784,
    parameter int VBP    = 31,
    parameter int VFP    = 511,
    parameter int HTOTAL = 800,
    parameter int VTOTAL = 521,
    parameter int HPULSE = 96,
    parameter int VPULSE = 2,
    parameter int PAD_H  = 100
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic [9:0] ballx,
    input  logic [9:0] bally,
    input  logic [9:0] l_pos,
    input  logic [9:0] r_pos,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_tick
);

    typedef struct packed {
        logic [9:0] ballx;
        logic [9:0] bally;
        logic [9:0] l_pos;
        logic [9:0] r_pos;
        logic [6:0] score_l;
        logic [6:0] score_r;
    } snap_t;

    localparam logic [9:0]  HLAST    = 10'(HTOTAL - 1);
    localparam logic [9:0]  VLAST    = 10'(VTOTAL - 1);
    localparam logic [9:0]  VFP_C    = 10'(VFP);
    localparam logic [10:0] HBP_W    = 11'(HBP);
    localparam logic [10:0] HFP_W    = 11'(HFP);
    localparam logic [10:0] VBP_W    = 11'(VBP);
    localparam logic [10:0] VFP_W    = 11'(VFP);
    localparam logic [10:0] HPULSE_W = 11'(HPULSE);
    localparam logic [10:0] VPULSE_W = 11'(VPULSE);
    localparam logic [10:0] PAD_W    = 11'(PAD_H);
    localparam logic [10:0] LPAD_X   = 11'(HBP + 65);
    localparam logic [10:0] RPAD_X   = 11'(HBP + 570);
    localparam logic [10:0] WALL0_Y  = 11'(VBP + 50);
    localparam logic [10:0] WALL1_Y  = 11'(VBP + 425);
    localparam logic [10:0] DIGL_X   = 11'(HBP + 260);
    localparam logic [10:0] DIGR_X   = 11'(HBP + 360);
    localparam logic [10:0] DIG_Y    = 11'(VBP + 5);

    localparam logic [7:0] C_BALL  = 8'b111_111_00;
    localparam logic [7:0] C_WHITE = 8'b111_111_11;
    localparam logic [7:0] C_DIGIT = 8'b000_111_00;

    localparam snap_t SNAP_RST = {10'(HBP + 320), 10'(VBP + 240), 10'(VBP + 190),
                                  10'(VBP + 190), 7'b1111110, 7'b1111110};

    logic [9:0] hc_q, hc_d, vc_q, vc_d;
    snap_t      snap_q, snap_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, tick_q, tick_d;
    logic [7:0] rgb_q, rgb_d;

    logic [10:0] x, y, bx, by, lp, rp;
    logic        active, in_ball, in_pad, in_wall, in_dig_l, in_dig_r, lit_l, lit_r;

    function automatic logic in_rng(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
        in_rng = (v >= lo) && (v < hi);
    endfunction

    // dx/dy are only meaningful inside the 20x40 digit box; callers gate on that.
    function automatic logic seg_lit(input logic [10:0] dx, input logic [10:0] dy,
                                     input logic [6:0] s);
        seg_lit = (s[6] && dy < 11'd4)
               || (s[5] && dx >= 11'd16 && dy < 11'd20)
               || (s[4] && dx >= 11'd16 && dy >= 11'd20)
               || (s[3] && dy >= 11'd36)
               || (s[2] && dx < 11'd4 && dy >= 11'd20)
               || (s[1] && dx < 11'd4 && dy < 11'd20)
               || (s[0] && dy >= 11'd18 && dy < 11'd22);
    endfunction

    always_comb begin
        hc_d   = hc_q + 10'd1;
        vc_d   = vc_q;
        snap_d = snap_q;
        if (hc_q == HLAST) begin
            hc_d = '0;
            if (vc_q == VLAST) begin
                vc_d   = '0;
                snap_d = {ballx, bally, l_pos, r_pos, score_l, score_r};
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end

        // 11-bit coordinates keep pos+size from wrapping back on screen.
        x  = {1'b0, hc_q};
        y  = {1'b0, vc_q};
        bx = {1'b0, snap_q.ballx};
        by = {1'b0, snap_q.bally};
        lp = {1'b0, snap_q.l_pos};
        rp = {1'b0, snap_q.r_pos};

        active   = in_rng(x, HBP_W, HFP_W) && in_rng(y, VBP_W, VFP_W);
        in_ball  = in_rng(x, bx, bx + 11'd8) && in_rng(y, by, by + 11'd8);
        in_pad   = (in_rng(x, LPAD_X, LPAD_X + 11'd10) && in_rng(y, lp, lp + PAD_W))
                || (in_rng(x, RPAD_X, RPAD_X + 11'd10) && in_rng(y, rp, rp + PAD_W));
        in_wall  = in_rng(y, WALL0_Y, WALL0_Y + 11'd5) || in_rng(y, WALL1_Y, WALL1_Y + 11'd5);
        in_dig_l = in_rng(x, DIGL_X, DIGL_X + 11'd20) && in_rng(y, DIG_Y, DIG_Y + 11'd40);
        in_dig_r = in_rng(x, DIGR_X, DIGR_X + 11'd20) && in_rng(y, DIG_Y, DIG_Y + 11'd40);
        lit_l    = in_dig_l && seg_lit(x - DIGL_X, y - DIG_Y, snap_q.score_l);
        lit_r    = in_dig_r && seg_lit(x - DIGR_X, y - DIG_Y, snap_q.score_r);

        rgb_d = '0;
        if (active) begin
            if (in_ball)             rgb_d = C_BALL;
            else if (in_pad)         rgb_d = C_WHITE;
            else if (lit_l || lit_r) rgb_d = C_DIGIT;
            else if (in_wall)        rgb_d = C_WHITE;
        end

        hsync_d = (x >= HPULSE_W);
        vsync_d = (y >= VPULSE_W);
        tick_d  = (hc_q == '0) && (vc_q == VFP_C);
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc_q    <= '0;
            vc_q    <= '0;
            snap_q  <= SNAP_RST;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            tick_q  <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            snap_q  <= snap_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = tick_q;
    assign red        = rgb_q[7:5];
    assign green      = rgb_q[4:2];
    assign blue       = rgb_q[1:0];

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench: a shrunken-timing instance exercises drawing, snapshots and
// frame timing; a default-timing instance checks reset and the real sync widths.
module tb_pong_vga_renderer;

    localparam int HT = 290, VT = 64, HBP = 4, HFP = 284, VBP = 2, VFP = 60;
    localparam int HP = 3, VP = 1, PH = 10;
    localparam int F  = HT * VT;
    localparam logic [7:0] BLK = 8'h00, YEL = 8'hFC, WHT = 8'hFF, GRN = 8'h1C;

    logic       dclk = 1'b0;
    logic       clr  = 1'b0;
    logic [9:0] ballx, bally, l_pos, r_pos;
    logic [6:0] score_l, score_r;
    logic       hsync, vsync, frame_tick;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       hsync_b, vsync_b, frame_tick_b;
    logic [2:0] red_b, green_b;
    logic [1:0] blue_b;

    int checks = 0, errors = 0, cyc = 0;
    int hs_lo = 0, vs_lo = 0, tick_n = 0, t1 = 0, t2 = 0;
    int hs_lo_b = 0, vs_lo_b = 0, tick_b = 0;
    bit mon_en = 1'b1;

    pong_vga_renderer #(
        .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .HTOTAL(HT), .VTOTAL(VT),
        .HPULSE(HP), .VPULSE(VP), .PAD_H(PH)
    ) u_dut (
        .dclk(dclk), .clr(clr), .ballx(ballx), .bally(bally), .l_pos(l_pos),
        .r_pos(r_pos), .score_l(score_l), .score_r(score_r), .hsync(hsync),
        .vsync(vsync), .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
    );

    pong_vga_renderer u_big (
        .dclk(dclk), .clr(clr), .ballx(ballx), .bally(bally), .l_pos(l_pos),
        .r_pos(r_pos), .score_l(score_l), .score_r(score_r), .hsync(hsync_b),
        .vsync(vsync_b), .red(red_b), .green(green_b), .blue(blue_b),
        .frame_tick(frame_tick_b)
    );

    always #5 dclk = ~dclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output seen after edge k reflects counter state k-1 increments past release.
    task automatic tick_to(input int tgt);
        bit moved;
        moved = 1'b0;
        if (tgt < cyc) chk("order", cyc, tgt);
        while (cyc < tgt) begin
            @(posedge dclk);
            cyc++;
            moved = 1'b1;
        end
        if (moved) #1;
    endtask

    task automatic px(input string tag, input int f, input int x, input int y,
                      input logic [7:0] exp);
        tick_to(f * F + y * HT + x + 1);
        chk(tag, {red, green, blue}, exp);
    endtask

    task automatic sy(input string tag, input int f, input int x, input int y,
                      input logic eh, input logic ev);
        tick_to(f * F + y * HT + x + 1);
        chk({tag, "_h"}, hsync, eh);
        chk({tag, "_v"}, vsync, ev);
    endtask

    always @(negedge dclk) begin
        if (mon_en && cyc >= 1) begin
            if (cyc <= 2 * F) begin
                if (!hsync) hs_lo++;
                if (!vsync) vs_lo++;
                if (frame_tick) begin
                    tick_n++;
                    if (tick_n == 1) t1 = cyc;
                    else if (tick_n == 2) t2 = cyc;
                end
            end
            if (cyc <= 2000) begin
                if (!hsync_b) hs_lo_b++;
                if (!vsync_b) vs_lo_b++;
            end
            if (frame_tick_b) tick_b++;
        end
    end

    initial begin
        ballx = 10'd100; bally = 10'd20; l_pos = 10'd10; r_pos = 10'd0;
        score_l = 7'b0110000; score_r = 7'b0000000;
        #1 clr = 1'b1;
        repeat (3) @(posedge dclk);
        #1;
        chk("rst_hsync", hsync, 1'b0);
        chk("rst_vsync", vsync, 1'b0);
        chk("rst_rgb", {red, green, blue}, BLK);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_big_hsync", hsync_b, 1'b0);
        chk("rst_big_rgb", {red_b, green_b, blue_b}, BLK);
        clr = 1'b0;

        // Frame 0: reset snapshot (ball/paddles off-screen, left score '0').
        sy("f0_s20", 0, 2, 0, 1'b0, 1'b0);
        sy("f0_s30", 0, 3, 0, 1'b1, 1'b0);
        sy("f0_s31", 0, 3, 1, 1'b1, 1'b1);
        px("f0_dig_a", 0, 264, 7, GRN);
        px("f0_noball", 0, 100, 20, BLK);
        px("f0_dig_g_off", 0, 274, 27, BLK);
        px("f0_dig_c", 0, 280, 27, GRN);
        px("f0_above_wall", 0, 100, 51, BLK);
        px("f0_wall_hbp_m1", 0, 3, 52, BLK);
        px("f0_wall_hbp", 0, 4, 52, WHT);
        px("f0_wall", 0, 100, 52, WHT);
        px("f0_wall_hfp_m1", 0, 283, 52, WHT);
        px("f0_wall_hfp", 0, 284, 52, BLK);
        px("f0_wall_last", 0, 100, 56, WHT);
        px("f0_below_wall", 0, 100, 57, BLK);

        // Frame 1: ball (100,20), l_pos 10, left score '1'.
        px("f1_dig_a_off", 1, 264, 7, BLK);
        px("f1_dig_dx15", 1, 279, 7, BLK);
        px("f1_dig_b", 1, 280, 7, GRN);
        px("f1_pad_x_lo", 1, 68, 10, BLK);
        px("f1_pad_top", 1, 69, 10, WHT);
        px("f1_pad_x_hi", 1, 78, 10, WHT);
        px("f1_pad_x_end", 1, 79, 10, BLK);
        tick_to(F + 15 * HT + 1);
        ballx = 10'd276; bally = 10'd30; l_pos = 10'd1020;
        px("f1_pad_bot", 1, 69, 19, WHT);
        px("f1_pad_bot_r", 1, 78, 19, WHT);
        px("f1_pad_end", 1, 69, 20, BLK);
        px("f1_ball_xlo", 1, 99, 20, BLK);
        px("f1_ball", 1, 100, 20, YEL);
        px("f1_ball_xend", 1, 108, 20, BLK);
        px("f1_ball_corner", 1, 107, 27, YEL);
        px("f1_ball_yend", 1, 100, 28, BLK);
        px("f1_newball_hidden", 1, 280, 30, GRN);
        px("f1_dig_c_last", 1, 283, 46, GRN);
        px("f1_dig_below", 1, 280, 47, BLK);

        // Frame 2: ball moved over the digit, paddle far out of range.
        px("f2_pad_noalias", 2, 69, 5, BLK);
        chk("tick_count", tick_n, 2);
        chk("tick_first", t1, VFP * HT + 1);
        chk("tick_period", t2 - t1, F);
        chk("hsync_low_2f", hs_lo, 2 * VT * HP);
        chk("vsync_low_2f", vs_lo, 2 * VP * HT);
        chk("big_hsync_low", hs_lo_b, 3 * 96);
        chk("big_vsync_low", vs_lo_b, 2 * 800);
        chk("big_no_tick", tick_b, 0);
        mon_en = 1'b0;
        px("f2_oldball_gone", 2, 100, 20, BLK);
        px("f2_ball_xlo", 2, 275, 30, BLK);
        px("f2_ball", 2, 276, 30, YEL);
        px("f2_ball_over_dig", 2, 280, 30, YEL);
        px("f2_ball_hfp", 2, 284, 30, BLK);
        px("f2_ball_corner", 2, 283, 37, YEL);
        px("f2_dig_under", 2, 280, 38, GRN);
        px("f2_wall", 2, 100, 52, WHT);

        // Mid-frame asynchronous reset.
        #1 clr = 1'b1;
        #1;
        chk("arst_rgb", {red, green, blue}, BLK);
        chk("arst_hsync", hsync, 1'b0);
        chk("arst_vsync", vsync, 1'b0);
        chk("arst_big_hsync", hsync_b, 1'b0);
        chk("arst_big_vsync", vsync_b, 1'b0);
        repeat (3) @(posedge dclk);
        #1;
        chk("arst_hold_tick", frame_tick, 1'b0);
        chk("arst_hold_rgb", {red, green, blue}, BLK);
        clr = 1'b0;
        cyc = 0;

        sy("r0_s20", 0, 2, 0, 1'b0, 1'b0);
        sy("r0_s30", 0, 3, 0, 1'b1, 1'b0);
        px("r0_pad_rst", 0, 69, 5, BLK);
        px("r0_dig_a", 0, 264, 7, GRN);
        px("r0_noball", 0, 100, 20, BLK);
        px("r0_snap_rst", 0, 280, 30, GRN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
